// File: rtl/config_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : config_write_queue
// Description : Buffers CPU peripheral writes (address, data) in a small FIFO
//               and replays them to the 64-bit config latch loader as
//               one-cycle write pulses. Nothing is issued while the loader
//               reports busy. The module also reports queue level, a sticky
//               overflow flag and a per-load completion pulse.
// Ports       : clk, rst_n         - clock, synchronous active-low reset
//               bus_wr/addr/wdata  - CPU write strobe, address, data
//               bus_ready          - queue not full
//               ldr_busy           - loader busy flag
//               ldr_write_req      - one-cycle write pulse to loader
//               ldr_address/data   - payload, valid with ldr_write_req
//               q_level            - current entry count
//               overflow / ovf_clr - sticky dropped-write flag and its clear
//               load_done          - pulse when a LOAD_ADDR-triggered load ends
// Revision    : 1.0 - initial release
// ============================================================================
module config_write_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [5:0] LOAD_ADDR = 6'hC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bus_wr,
    input  logic [5:0]               bus_addr,
    input  logic [31:0]              bus_wdata,
    output logic                     bus_ready,
    input  logic                     ldr_busy,
    output logic                     ldr_write_req,
    output logic [5:0]               ldr_address,
    output logic [31:0]              ldr_data,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     load_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [37:0]   mem_q [DEPTH];
    logic [5:0]    ldr_address_q;
    logic [31:0]   ldr_data_q;
    logic          overflow_q;
    logic          load_pending_q;
    logic          busy_q;
    logic          load_done_q;

    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_done;
    logic          w_load_issued;

    // Fullness uses the registered count only: a pop in the same cycle does
    // not free a slot for the incoming write.
    assign w_full    = (count_q == C_FULL);
    assign w_push    = bus_wr && !w_full;
    assign w_drop    = bus_wr && w_full;
    assign bus_ready = !w_full;

    // Completion: loader was busy last cycle and has just gone idle.
    assign w_done        = load_pending_q && busy_q && !ldr_busy;
    assign w_load_issued = ldr_write_req && (ldr_address_q == LOAD_ADDR);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state / pop decision ----------------
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !ldr_busy) begin
                    w_pop   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // count_q already reflects the pop that fed the current pulse.
                // A LOAD_ADDR issue always returns to IDLE: the loader raises
                // busy one cycle after its pulse, so a gap is needed before
                // busy can be trusted again.
                if ((ldr_address_q != LOAD_ADDR) && (count_q != '0) && !ldr_busy) begin
                    w_pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ldr_write_req = (state_q == S_ISSUE);
    end

    // ---------------- Storage array (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus_addr, bus_wdata};
        end
    end

    // ---------------- Pointers, count, loader payload, status ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ldr_address_q  <= '0;
            ldr_data_q     <= '0;
            overflow_q     <= 1'b0;
            load_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q      <= rd_ptr_q + PW'(1);
                ldr_address_q <= mem_q[rd_ptr_q][37:32];
                ldr_data_q    <= mem_q[rd_ptr_q][31:0];
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Set wins over clear.
            if (w_drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            busy_q         <= ldr_busy;
            load_done_q    <= w_done;
            load_pending_q <= w_load_issued || (load_pending_q && !w_done);
        end
    end

    assign ldr_address = ldr_address_q;
    assign ldr_data    = ldr_data_q;
    assign q_level     = count_q;
    assign overflow    = overflow_q;
    assign load_done   = load_done_q;

endmodule
`default_nettype wire

// File: tb/tb_config_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_write_queue
// Description : Directed self-checking bench for config_write_queue.
//               Inputs change 1 ns after each rising edge; outputs are
//               observed at the same point, i.e. the state after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_write_queue;

    logic        clk;
    logic        rst_n;
    logic        bus_wr;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        ldr_busy;
    logic        ldr_write_req;
    logic [5:0]  ldr_address;
    logic [31:0] ldr_data;
    logic [2:0]  q_level;
    logic        overflow;
    logic        ovf_clr;
    logic        load_done;

    int checks;
    int errors;

    config_write_queue #(
        .DEPTH     (4),
        .LOAD_ADDR (6'hC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_wr        (bus_wr),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .ldr_busy      (ldr_busy),
        .ldr_write_req (ldr_write_req),
        .ldr_address   (ldr_address),
        .ldr_data      (ldr_data),
        .q_level       (q_level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .load_done     (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
        ldr_busy = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (ldr_write_req !== 1'b0 || ldr_address !== 6'h0 || ldr_data !== 32'h0 ||
            q_level !== 3'd0 || overflow !== 1'b0 || load_done !== 1'b0 || bus_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h data=%h lvl=%0d ovf=%b done=%b rdy=%b expected 0 0 0 0 0 0 1",
                     ldr_write_req, ldr_address, ldr_data, q_level, overflow, load_done, bus_ready);
        end
        tick();
    endtask

    task automatic test_single();
        // cycle 0
        bus_wr = 1'b1; bus_addr = 6'h08; bus_wdata = 32'hDEADBEEF;
        tick(); // cycle 1
        bus_wr = 1'b0;
        checks++;
        if (q_level !== 3'd1 || ldr_write_req !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: lvl=%0d req=%b expected 1 0", q_level, ldr_write_req);
        end
        tick(); // cycle 2
        checks++;
        if (ldr_write_req !== 1'b1 || ldr_address !== 6'h08 || ldr_data !== 32'hDEADBEEF || q_level !== 3'd0) begin
            errors++;
            $display("FAIL single_c2: req=%b addr=%h data=%h lvl=%0d expected 1 08 deadbeef 0",
                     ldr_write_req, ldr_address, ldr_data, q_level);
        end
        tick(); // cycle 3
        checks++;
        if (ldr_write_req !== 1'b0) begin
            errors++;
            $display("FAIL single_c3: req=%b expected 0", ldr_write_req);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus_wr = 1'b1; bus_addr = 6'h08; bus_wdata = 32'h11111111;   // cycle 0
        tick();
        bus_addr = 6'h0C; bus_wdata = 32'h22222222;                   // cycle 1
        tick();
        bus_wr = 1'b0;                                                // cycle 2
        checks++;
        if (ldr_write_req !== 1'b1 || ldr_address !== 6'h08 || ldr_data !== 32'h11111111) begin
            errors++;
            $display("FAIL b2b_first: req=%b addr=%h data=%h expected 1 08 11111111",
                     ldr_write_req, ldr_address, ldr_data);
        end
        tick();                                                       // cycle 3
        checks++;
        if (ldr_write_req !== 1'b1 || ldr_address !== 6'h0C || ldr_data !== 32'h22222222) begin
            errors++;
            $display("FAIL b2b_second: req=%b addr=%h data=%h expected 1 0c 22222222",
                     ldr_write_req, ldr_address, ldr_data);
        end
        // busy high cycles 4..20 (17 cycles); falls at 21, done pulse at 22
        for (int cyc = 4; cyc <= 25; cyc++) begin
            tick();
            ldr_busy = (cyc <= 20);
            checks++;
            if (load_done !== (cyc == 22) || ldr_write_req !== 1'b0) begin
                errors++;
                $display("FAIL load_done_c%0d: done=%b req=%b expected %b 0",
                         cyc, load_done, ldr_write_req, (cyc == 22));
            end
        end
        ldr_busy = 1'b0;
        tick();
    endtask

    task automatic test_busy_block();
        bus_wr = 1'b1; bus_addr = 6'h0C; bus_wdata = 32'hAAAA0000;   // cycle 0
        tick();
        bus_addr = 6'h08; bus_wdata = 32'hBBBB0000;                   // cycle 1
        tick();
        bus_wr = 1'b0;                                                // cycle 2
        checks++;
        if (ldr_write_req !== 1'b1 || ldr_address !== 6'h0C) begin
            errors++;
            $display("FAIL block_first: req=%b addr=%h expected 1 0c", ldr_write_req, ldr_address);
        end
        // busy high cycles 3..7; second pulse expected at 9, done pulse at 9
        for (int cyc = 3; cyc <= 12; cyc++) begin
            tick();
            ldr_busy = (cyc <= 7);
            checks++;
            if (ldr_write_req !== (cyc == 9) || (ldr_write_req && ldr_busy)) begin
                errors++;
                $display("FAIL block_c%0d: req=%b busy=%b expected req %b",
                         cyc, ldr_write_req, ldr_busy, (cyc == 9));
            end
            if (cyc == 9) begin
                checks++;
                if (ldr_address !== 6'h08 || ldr_data !== 32'hBBBB0000 || load_done !== 1'b1) begin
                    errors++;
                    $display("FAIL block_second: addr=%h data=%h done=%b expected 08 bbbb0000 1",
                             ldr_address, ldr_data, load_done);
                end
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        ldr_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin                             // cycles 0..4
            bus_wr = 1'b1; bus_addr = 6'(i + 1); bus_wdata = 32'h5000_0000 + 32'(i + 1);
            if (i == 3) begin
                checks++;
                if (bus_ready !== 1'b1 || q_level !== 3'd3) begin
                    errors++;
                    $display("FAIL ovf_before_full: rdy=%b lvl=%0d expected 1 3", bus_ready, q_level);
                end
            end
            if (i == 4) begin
                checks++;
                if (bus_ready !== 1'b0 || q_level !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: rdy=%b lvl=%0d ovf=%b expected 0 4 0", bus_ready, q_level, overflow);
                end
            end
            tick();
        end
        bus_wr = 1'b0; ovf_clr = 1'b1;                                // cycle 5
        checks++;
        if (overflow !== 1'b1 || q_level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b lvl=%0d expected 1 4", overflow, q_level);
        end
        tick();                                                       // cycle 6
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
        bus_wr = 1'b1; bus_addr = 6'h3F; bus_wdata = 32'hFFFFFFFF;    // drop + clear together
        tick();                                                       // cycle 7
        bus_wr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b expected 1", overflow);
        end
        ldr_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin                             // cycles 8..12
            tick();
            ovf_clr = 1'b0;
            checks++;
            if (i < 4) begin
                if (ldr_write_req !== 1'b1 || ldr_address !== 6'(i + 1) ||
                    ldr_data !== 32'h5000_0000 + 32'(i + 1)) begin
                    errors++;
                    $display("FAIL drain_%0d: req=%b addr=%h data=%h expected 1 %h %h", i,
                             ldr_write_req, ldr_address, ldr_data, 6'(i + 1), 32'h5000_0000 + 32'(i + 1));
                end
            end else if (ldr_write_req !== 1'b0 || q_level !== 3'd0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL drain_end: req=%b lvl=%0d ovf=%b expected 0 0 0", ldr_write_req, q_level, overflow);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        ldr_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin                             // cycles 0..3
            bus_wr = 1'b1; bus_addr = 6'h10 + 6'(i); bus_wdata = 32'h7000_0000 + 32'(i);
            tick();
        end
        bus_wr = 1'b0; ldr_busy = 1'b0;                               // cycle 4
        tick();                                                       // cycle 5
        checks++;
        if (ldr_write_req !== 1'b1 || ldr_address !== 6'h10 || q_level !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre: req=%b addr=%h lvl=%0d expected 1 10 3", ldr_write_req, ldr_address, q_level);
        end
        rst_n = 1'b0;
        tick();                                                       // cycle 6
        rst_n = 1'b1;
        checks++;
        if (ldr_write_req !== 1'b0 || ldr_address !== 6'h0 || ldr_data !== 32'h0 ||
            q_level !== 3'd0 || overflow !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: req=%b addr=%h data=%h lvl=%0d ovf=%b done=%b expected all 0",
                     ldr_write_req, ldr_address, ldr_data, q_level, overflow, load_done);
        end
        for (int cyc = 7; cyc <= 12; cyc++) begin
            tick();
            checks++;
            if (ldr_write_req !== 1'b0 || q_level !== 3'd0) begin
                errors++;
                $display("FAIL rst_quiet_c%0d: req=%b lvl=%0d expected 0 0", cyc, ldr_write_req, q_level);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_block();
        test_overflow();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
